// File: rtl/nv_nvdla_pdp_rdma_reg_host_pkg.sv
// Shared definitions for the PDP RDMA register-programming host.
// Holds the single-register-space offsets, the status encoding, the host FSM
// state type, and helpers for status-field extraction and offset legality.
package nv_nvdla_pdp_rdma_reg_host_pkg;

  localparam logic [11:0] PTR_OFS     = 12'h004;
  localparam logic [11:0] STAT_OFS    = 12'h000;
  localparam logic [1:0]  STATUS_IDLE = 2'b00;

  // Status word carries one 2-bit field per register group.
  localparam int unsigned STAT_LSB_G0 = 0;
  localparam int unsigned STAT_LSB_G1 = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PTR,
    ST_RD_STAT,
    ST_GAP,
    ST_CFG,
    ST_FLIP,
    ST_PTR_WR,
    ST_DONE
  } state_e;

  function automatic logic [1:0] stat_field(input logic [31:0] word, input logic grp);
    return grp ? word[STAT_LSB_G1 +: 2] : word[STAT_LSB_G0 +: 2];
  endfunction

  // The caller must not touch the single-register-space control registers.
  function automatic logic ofs_illegal(input logic [11:0] ofs);
    return (ofs == PTR_OFS) || (ofs == STAT_OFS);
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_rdma_poll_timer.sv
// Poll pacing for the register host.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   gap_load_i    : start an inter-poll gap of POLL_GAP cycles
//   poll_inc_i    : count one busy status read
//   poll_clr_i    : clear the busy-read count
//   gap_done_o    : current gap cycle is the last one
//   timeout_o     : the status read in progress is the last one allowed
module nv_nvdla_pdp_rdma_poll_timer
  import nv_nvdla_pdp_rdma_reg_host_pkg::*;
#(
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic gap_load_i,
  input  logic poll_inc_i,
  input  logic poll_clr_i,
  output logic gap_done_o,
  output logic timeout_o
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    poll_q, poll_d;

  always_comb begin
    gap_d = gap_q;
    if (gap_load_i) begin
      gap_d = GW'(POLL_GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_comb begin
    poll_d = poll_q;
    if (poll_clr_i) begin
      poll_d = '0;
    end else if (poll_inc_i) begin
      poll_d = poll_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_q  <= '0;
      poll_q <= '0;
    end else begin
      gap_q  <= gap_d;
      poll_q <= poll_d;
    end
  end

  assign gap_done_o = (gap_q == '0);
  assign timeout_o  = (poll_q == 8'(TIMEOUT_POLLS - 1));

endmodule

// File: rtl/nv_nvdla_pdp_rdma_reg_host.sv
// Register-bus initiator programming one PDP RDMA register group.
// Reads the producer pointer, polls that group's status until idle, streams
// caller config writes, then flips the producer pointer.
//   nvdla_core_clk/rst        : clock, synchronous active-high reset
//   launch_valid/ready        : request to program the next group
//   cfg_valid/ready/offset/data/last : config write beats
//   reg_offset/wr_data/wr_en  : register bus to the RDMA slave (registered)
//   reg_rd_data               : combinational slave read data for reg_offset
//   done_valid/group/err      : one-cycle completion report
//   busy                      : not idle
module nv_nvdla_pdp_rdma_reg_host
  import nv_nvdla_pdp_rdma_reg_host_pkg::*;
#(
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        launch_valid,
  output logic        launch_ready,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [11:0] cfg_offset,
  input  logic [31:0] cfg_data,
  input  logic        cfg_last,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data,
  output logic        done_valid,
  output logic        done_group,
  output logic        done_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        grp_q, grp_d;
  logic        err_ill_q, err_ill_d;
  logic [11:0] reg_offset_q, reg_offset_d;
  logic [31:0] reg_wr_data_q, reg_wr_data_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        launch_ready_q, launch_ready_d;
  logic        cfg_ready_q, cfg_ready_d;
  logic        done_valid_q, done_valid_d;
  logic        done_group_q, done_group_d;
  logic        done_err_q, done_err_d;
  logic        busy_q, busy_d;

  logic gap_load, poll_inc, poll_clr, gap_done, timeout;
  logic stat_busy;
  logic rd_unused;

  assign stat_busy = (stat_field(reg_rd_data, grp_q) != STATUS_IDLE);
  assign rd_unused = ^{reg_rd_data[31:18], reg_rd_data[15:2]};

  nv_nvdla_pdp_rdma_poll_timer #(
    .POLL_GAP      (POLL_GAP),
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) u_timer (
    .clk_i      (nvdla_core_clk),
    .rst_i      (nvdla_core_rst),
    .gap_load_i (gap_load),
    .poll_inc_i (poll_inc),
    .poll_clr_i (poll_clr),
    .gap_done_o (gap_done),
    .timeout_o  (timeout)
  );

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (launch_valid) state_d = ST_RD_PTR;
      ST_RD_PTR:  state_d = ST_RD_STAT;
      ST_RD_STAT: begin
        if (!stat_busy)   state_d = ST_CFG;
        else if (timeout) state_d = ST_DONE;
        else              state_d = ST_GAP;
      end
      ST_GAP:     if (gap_done) state_d = ST_RD_STAT;
      ST_CFG:     if (cfg_valid && cfg_last) state_d = ST_FLIP;
      ST_FLIP:    state_d = ST_PTR_WR;
      ST_PTR_WR:  state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Every output is a flop, so each value is prepared one cycle ahead from
  // the state being entered.
  always_comb begin
    grp_d          = grp_q;
    err_ill_d      = err_ill_q;
    reg_offset_d   = reg_offset_q;
    reg_wr_data_d  = reg_wr_data_q;
    reg_wr_en_d    = 1'b0;
    done_valid_d   = 1'b0;
    done_group_d   = done_group_q;
    done_err_d     = done_err_q;
    launch_ready_d = (state_d == ST_IDLE);
    cfg_ready_d    = (state_d == ST_CFG);
    busy_d         = (state_d != ST_IDLE);
    gap_load       = 1'b0;
    poll_inc       = 1'b0;
    poll_clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RD_PTR) reg_offset_d = PTR_OFS;
      end
      ST_RD_PTR: begin
        grp_d        = reg_rd_data[0];
        reg_offset_d = STAT_OFS;
      end
      ST_RD_STAT: begin
        if (stat_busy) begin
          poll_inc = 1'b1;
          if (timeout) begin
            done_valid_d = 1'b1;
            done_group_d = grp_q;
            done_err_d   = 1'b1;
          end else begin
            gap_load = 1'b1;
          end
        end
      end
      ST_CFG: begin
        if (cfg_valid) begin
          if (ofs_illegal(cfg_offset)) begin
            err_ill_d = 1'b1;
          end else begin
            reg_wr_en_d   = 1'b1;
            reg_offset_d  = cfg_offset;
            reg_wr_data_d = cfg_data;
          end
        end
      end
      ST_FLIP: begin
        reg_offset_d  = PTR_OFS;
        reg_wr_data_d = {31'b0, ~grp_q};
        reg_wr_en_d   = 1'b1;
      end
      ST_PTR_WR: begin
        done_valid_d = 1'b1;
        done_group_d = grp_q;
        done_err_d   = err_ill_q;
      end
      ST_DONE: begin
        poll_clr  = 1'b1;
        err_ill_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      grp_q          <= 1'b0;
      err_ill_q      <= 1'b0;
      reg_offset_q   <= '0;
      reg_wr_data_q  <= '0;
      reg_wr_en_q    <= 1'b0;
      launch_ready_q <= 1'b1;
      cfg_ready_q    <= 1'b0;
      done_valid_q   <= 1'b0;
      done_group_q   <= 1'b0;
      done_err_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      grp_q          <= grp_d;
      err_ill_q      <= err_ill_d;
      reg_offset_q   <= reg_offset_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg_wr_en_q    <= reg_wr_en_d;
      launch_ready_q <= launch_ready_d;
      cfg_ready_q    <= cfg_ready_d;
      done_valid_q   <= done_valid_d;
      done_group_q   <= done_group_d;
      done_err_q     <= done_err_d;
      busy_q         <= busy_d;
    end
  end

  assign reg_offset   = reg_offset_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign launch_ready = launch_ready_q;
  assign cfg_ready    = cfg_ready_q;
  assign done_valid   = done_valid_q;
  assign done_group   = done_group_q;
  assign done_err     = done_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_reg_host.sv
// Scoreboard bench for nv_nvdla_pdp_rdma_reg_host: the driver pushes the
// expected bus events (cycle-stamped) and a monitor matches what the DUT shows.
module tb_nv_nvdla_pdp_rdma_reg_host;

  localparam int PG = 4;
  localparam int TP = 3;
  localparam int K_RDY = 0, K_WR = 1, K_DONE = 2, K_SNAP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_valid, launch_ready;
  logic        cfg_valid, cfg_ready, cfg_last;
  logic [11:0] cfg_offset, reg_offset;
  logic [31:0] cfg_data, reg_wr_data, reg_rd_data;
  logic        reg_wr_en, done_valid, done_group, done_err, busy;

  typedef struct {
    int          kind;
    int          cyc;
    logic [11:0] ofs;
    logic [31:0] dat;
    logic        grp;
    logic        err;
    logic        lr;
    logic        bsy;
    logic        chk_ofs;
  } ev_t;

  ev_t evq[$];
  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;

  // Slave model: pointer word at 0x004, status busy until busy_until.
  logic [31:0] ptr_word = '0, busy_word = '0, idle_word = '0;
  int          busy_until = 0;
  logic [11:0] bo[8];
  logic [31:0] bd[8];
  int          bg[8];

  assign reg_rd_data = (reg_offset == 12'h004) ? ptr_word :
                       (reg_offset == 12'h000) ? ((cyc < busy_until) ? busy_word : idle_word) :
                       32'hDEAD_BEEF;

  nv_nvdla_pdp_rdma_reg_host #(
    .POLL_GAP      (PG),
    .TIMEOUT_POLLS (TP)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .launch_valid   (launch_valid),
    .launch_ready   (launch_ready),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_offset     (cfg_offset),
    .cfg_data       (cfg_data),
    .cfg_last       (cfg_last),
    .reg_offset     (reg_offset),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .reg_rd_data    (reg_rd_data),
    .done_valid     (done_valid),
    .done_group     (done_group),
    .done_err       (done_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input int kind, input int c, input logic [11:0] ofs,
                                  input logic [31:0] dat, input logic g, input logic er,
                                  input logic lr, input logic bsy, input logic chk_ofs);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ofs = ofs; e.dat = dat; e.grp = g; e.err = er;
    e.lr = lr; e.bsy = bsy; e.chk_ofs = chk_ofs;
    evq.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic match(input int kind, input string nm, input logic [11:0] ofs,
                       input logic [31:0] dat, input logic g, input logic er);
    ev_t e;
    if (evq.size() == 0) begin
      vecs++; errs++;
      $display("FAIL unexpected_%s at cycle %0d: got event, expected none", nm, cyc);
    end else begin
      e = evq.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk({nm, "_cycle"}, cyc, e.cyc);
      if (kind == K_WR) begin
        chk("wr_offset", {20'b0, ofs}, {20'b0, e.ofs});
        chk("wr_data", dat, e.dat);
      end else if (kind == K_DONE) begin
        chk("done_group", {31'b0, g}, {31'b0, e.grp});
        chk("done_err", {31'b0, er}, {31'b0, e.err});
      end
    end
  endtask

  task automatic monitor_loop();
    ev_t  e;
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (evq.size() > 0 && evq[0].kind == K_SNAP && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        chk("snap_launch_ready", {31'b0, launch_ready}, {31'b0, e.lr});
        chk("snap_busy", {31'b0, busy}, {31'b0, e.bsy});
        chk("snap_wr_en", {31'b0, reg_wr_en}, 32'd0);
        if (e.chk_ofs) chk("snap_offset", {20'b0, reg_offset}, {20'b0, e.ofs});
      end
      if (cfg_ready && !prev_rdy) match(K_RDY, "cfg_ready_rise", '0, '0, 1'b0, 1'b0);
      if (reg_wr_en)  match(K_WR, "write", reg_offset, reg_wr_data, 1'b0, 1'b0);
      if (done_valid) match(K_DONE, "done", '0, '0, done_group, done_err);
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        vecs++; errs++;
        $display("FAIL missing_event kind %0d: got nothing, expected at cycle %0d", e.kind, e.cyc);
      end
      prev_rdy = cfg_ready;
    end
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (evq.size() > 0 && n < k) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (evq.size() > 0) begin
      vecs++; errs++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", evq.size());
      evq.delete();
    end
  endtask

  task automatic launch(input logic [31:0] ptr, input int nbusy, input logic [31:0] bw,
                        input logic [31:0] iw, input int nbeats, input bit tmo, input bit rst_first);
    int          n, t, c;
    logic        g, ill_seen;
    logic [11:0] last_ofs;
    n = 0;
    while (!launch_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!launch_ready) begin
      vecs++; errs++;
      $display("FAIL launch_ready_wait: got 0, expected 1");
      return;
    end
    g          = ptr[0];
    ptr_word   = ptr;
    busy_word  = bw;
    idle_word  = iw;
    t          = cyc;
    busy_until = t + 2 + (PG + 1) * nbusy;
    launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
    if (tmo) begin
      push_ev(K_DONE, t + 3 + (PG + 1) * (TP - 1), '0, '0, g, 1'b1, 1'b0, 1'b0, 1'b0);
      push_ev(K_SNAP, t + 4 + (PG + 1) * (TP - 1), '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      drain(80);
      return;
    end
    push_ev(K_RDY, t + 3 + (PG + 1) * nbusy, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    last_ofs = 12'h000;
    ill_seen = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      for (int k = 0; k < bg[i]; k++) begin
        cfg_valid = 1'b0;
        if (i > 0) push_ev(K_SNAP, cyc + 1, last_ofs, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
      end
      cfg_valid  = 1'b1;
      cfg_offset = bo[i];
      cfg_data   = bd[i];
      cfg_last   = (i == nbeats - 1);
      n = 0;
      while (!cfg_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!cfg_ready) begin
        vecs++; errs++;
        $display("FAIL cfg_ready_wait: got 0, expected 1");
        cfg_valid = 1'b0;
        drain(10);
        return;
      end
      c = cyc;
      if (bo[i] == 12'h000 || bo[i] == 12'h004) begin
        ill_seen = 1'b1;
        push_ev(K_SNAP, c + 1, last_ofs, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      end else begin
        push_ev(K_WR, c + 1, bo[i], bd[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        last_ofs = bo[i];
      end
      if (i == nbeats - 1) begin
        push_ev(K_WR, c + 2, 12'h004, {31'b0, ~g}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_ev(K_DONE, c + 3, '0, '0, g, ill_seen, 1'b0, 1'b0, 1'b0);
        push_ev(K_SNAP, c + 4, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      if (rst_first) begin
        cfg_valid = 1'b0;
        rst = 1'b1;
        push_ev(K_SNAP, cyc + 1, 12'h000, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drain(10);
        return;
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    drain(20);
  endtask

  task automatic run_tests();
    rst = 1'b1; launch_valid = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    cfg_offset = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    push_ev(K_SNAP, cyc + 1, 12'h000, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain(5);

    // Idle group 0, three beats at full rate.
    bo[0] = 12'h010; bd[0] = 32'hA; bg[0] = 0;
    bo[1] = 12'h014; bd[1] = 32'hB; bg[1] = 0;
    bo[2] = 12'h018; bd[2] = 32'hC; bg[2] = 0;
    launch(32'h0, 0, 32'h0, 32'h0, 3, 1'b0, 1'b0);

    // Group 1 busy for two polls, then idle.
    bo[0] = 12'h040; bd[0] = 32'h1234; bg[0] = 0;
    bo[1] = 12'h044; bd[1] = 32'h5678; bg[1] = 0;
    launch(32'h1, 2, 32'h0001_0000, 32'h0, 2, 1'b0, 1'b0);

    // Group 0 stuck busy: timeout after TP reads.
    launch(32'h0, 100, 32'h0000_0002, 32'h0000_0002, 0, 1'b1, 1'b0);

    // Illegal beat mid-stream; group 1 idle while group 0 field is busy.
    bo[0] = 12'h020; bd[0] = 32'h11; bg[0] = 0;
    bo[1] = 12'h000; bd[1] = 32'h22; bg[1] = 0;
    bo[2] = 12'h024; bd[2] = 32'h33; bg[2] = 0;
    launch(32'h1, 0, 32'h0, 32'h0000_0003, 3, 1'b0, 1'b0);

    // Back-pressure: cfg_valid 1,0,0,1.
    bo[0] = 12'h050; bd[0] = 32'hA5; bg[0] = 0;
    bo[1] = 12'h054; bd[1] = 32'h5A; bg[1] = 2;
    launch(32'h0, 0, 32'h0, 32'h0, 2, 1'b0, 1'b0);

    // Reset after the first beat.
    bo[0] = 12'h030; bd[0] = 32'h1; bg[0] = 0;
    bo[1] = 12'h034; bd[1] = 32'h2; bg[1] = 0;
    launch(32'h0, 0, 32'h0, 32'h0, 2, 1'b0, 1'b1);

    // Clean launch afterwards.
    bo[0] = 12'h060; bd[0] = 32'hCAFE; bg[0] = 0;
    bo[1] = 12'h064; bd[1] = 32'hBEEF; bg[1] = 0;
    launch(32'h1, 0, 32'h0, 32'h0, 2, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
  endtask

  initial begin
    fork
      monitor_loop();
      run_tests();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_pdp_rdma_reg_host.md
# nv_nvdla_pdp_rdma_reg_host

Register-bus initiator that programs one PDP RDMA register group through the single-register space (S_POINTER at 0x004, S_STATUS at 0x000). Per launch it:
- reads the producer pointer and polls that group's status until idle;
- streams caller-supplied config writes;
- flips the producer pointer.

It sits between a host command source and the PDP RDMA register slave, and drives that slave's `reg_offset` / `reg_wr_data` / `reg_wr_en` port directly.

## Interface
- `POLL_GAP`, 4: idle cycles between successive status polls (≥1).
- `TIMEOUT_POLLS`, 255: status reads allowed before giving up (≥1, ≤255).
- `nvdla_core_clk` in 1: single clock.
- `nvdla_core_rst` in 1: reset, synchronous, active-high.
- `launch_valid` in 1 / `launch_ready` out 1: request to program the next group.
- `cfg_valid` in 1 / `cfg_ready` out 1: config write beat handshake.
- `cfg_offset` in 12: target register offset of beat.
- `cfg_data` in 32: write data of beat.
- `cfg_last` in 1: final beat of this launch.
- `reg_offset` out 12: register bus address.
- `reg_wr_data` out 32: register bus write data.
- `reg_wr_en` out 1: write strobe, one cycle per write.
- `reg_rd_data` in 32: combinational read data from slave for current `reg_offset`.
- `done_valid` out 1: one-cycle completion pulse.
- `done_group` out 1: group programmed (the producer value read).
- `done_err` out 1: timeout or illegal offset; valid with `done_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- All bus outputs and `done_*` are flops. Reset value 0 for every output, except `launch_ready`, which is 1 (IDLE).
- FSM states: IDLE, RD_PTR, RD_STAT, GAP, CFG, FLIP, PTR_WR, DONE.
- **IDLE**: `launch_ready`=1. On launch handshake → RD_PTR.
- **RD_PTR**: `reg_offset`=0x004, `reg_wr_en`=0. Capture `grp` = `reg_rd_data[0]` at end of cycle → RD_STAT.
- **RD_STAT**: `reg_offset`=0x000. Sample status field: bits[1:0] if `grp`=0, bits[17:16] if `grp`=1.
  - Field == 2'b00 → CFG.
  - Otherwise `poll_cnt`++. If `poll_cnt` reaches `TIMEOUT_POLLS` → DONE with err=1; else → GAP.
- **GAP**: `reg_wr_en`=0 for `POLL_GAP` cycles → RD_STAT.
- **CFG**: `cfg_ready`=1.
  - Each handshake loads the bus flops, so the write appears the following cycle (`reg_wr_en`=1, offset/data of beat).
  - Cycles with no handshake → `reg_wr_en`=0, offset/data hold.
  - Beat with `cfg_offset` 0x000 or 0x004: consumed, write suppressed, sticky `err_ill` set.
  - Handshake with `cfg_last` → FLIP.
- **FLIP**: the last cfg write is on the bus; `cfg_ready`=0 → PTR_WR.
- **PTR_WR**: `reg_offset`=0x004, `reg_wr_data`={31'b0,~`grp`}, `reg_wr_en`=1 → DONE.
- **DONE**: `done_valid`=1, `done_group`=`grp`, `done_err`=timeout|`err_ill` → IDLE. Clear `poll_cnt` and `err_ill`.
- Timeout path: no cfg beats consumed, no pointer write. The caller must drop its pending cfg stream.
- A zero-length config is impossible: `cfg_last` is required. The first beat may be last.
- Reset at any point: next edge → IDLE, `reg_wr_en`=0. No partial pointer write is retried.

## Timing
- Launch handshake at cycle T; RD_PTR at T+1; RD_STAT at T+2.
- Idle status: CFG from T+3, `cfg_ready`=1 at T+3.
- Each cfg beat accepted at C appears on the bus at C+1. Full throughput: one write per cycle.
- Last beat accepted at L: last write at L+1, pointer write at L+2, `done_valid` at L+3, `launch_ready` at L+4.
- Each busy poll adds `POLL_GAP`+1 cycles.
- Reads use the combinational slave path: data is sampled at the end of the same cycle the offset is driven.

## Structure
- Package `nv_nvdla_pdp_rdma_reg_host_pkg`:
  - `PTR_OFS`=12'h004, `STAT_OFS`=12'h000, `STATUS_IDLE`=2'b00;
  - FSM state enum;
  - status-field bit positions (0, 16).
- Sub-module `nv_nvdla_pdp_rdma_poll_timer`: owns the GAP down-counter and `poll_cnt` up-counter; outputs `gap_done` and `timeout`.

## Test plan
- **Idle group 0, 3 beats**: rd_data at 0x004 = 0x0000_0000, at 0x000 = 0x0000_0000; beats (0x010,0xA), (0x014,0xB), (0x018,0xC last).
  - Expect writes 0x010/A, 0x014/B, 0x018/C on consecutive cycles, then 0x004 ← 0x1.
  - Expect `done_group`=0, `done_err`=0, `done_valid` 3 cycles after last accept.
- **Group 1 busy twice, then idle**: producer=1; status 0x0001_0000 twice, then 0.
  - Expect 3 status reads spaced `POLL_GAP`+1 cycles, then config, then 0x004 ← 0x0, `done_group`=1.
- **Timeout**: `TIMEOUT_POLLS`=3, status stuck 0x0000_0002 (group 0 busy).
  - Expect exactly 3 status reads, zero writes, `cfg_ready` never high, `done_err`=1.
- **Illegal beat**: beat offset 0x000 mid-stream.
  - Expect no `reg_wr_en` for that beat, other writes issued, pointer flipped, `done_err`=1.
- **Back-pressure**: `cfg_valid` toggles 1,0,0,1(last).
  - Expect `reg_wr_en` pattern 1,0,0,1 shifted by one cycle, and offsets held in the gaps.
- **Reset mid-CFG**: assert `nvdla_core_rst` after the first beat.
  - Expect `reg_wr_en`=0, `launch_ready`=1, `busy`=0 on the next edge, no pointer write, and a clean launch afterward.
